sequence_generator_fsm: RTL and testbench



---
 rtl/sequence_generator_fsm.sv | 123 ++++++++++++
 tb/tb_sequence_generator_fsm.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_generator_fsm.sv
// Serial MSB-first pattern generator with optional repeats separated by one-cycle gaps.
// First bit one cycle after the start edge; no backpressure, start is ignored while busy.
module sequence_generator_fsm #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             sequence_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LP_MAX_LEN = LEN_W'(PAT_W);

    state_t             r_state;
    state_t             w_next;
    logic [PAT_W-1:0]   r_pat;
    logic [PAT_W-1:0]   r_shift;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]   r_rep;

    logic [LEN_W-1:0]   w_eff_len;
    logic [PAT_W-1:0]   w_aligned;
    logic               w_launch;
    logic               w_last_bit;

    // Oversized lengths clamp to the full pattern; left-align so the first bit sits at the MSB.
    assign w_eff_len  = (pat_len > LP_MAX_LEN) ? LP_MAX_LEN : pat_len;
    assign w_aligned  = pattern << (LP_MAX_LEN - w_eff_len);
    assign w_launch   = start && (pat_len != '0);
    assign w_last_bit = (r_bit_cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = w_launch ? S_SHIFT : S_IDLE;
            S_SHIFT: begin
                if (!w_last_bit)
                    w_next = S_SHIFT;
                else if (r_rep == '0)
                    w_next = S_DONE;
                else
                    w_next = S_GAP;
            end
            S_GAP:   w_next = S_SHIFT;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pat     <= '0;
            r_shift   <= '0;
            r_len     <= '0;
            r_bit_cnt <= '0;
            r_rep     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_pat     <= w_aligned;
                        r_shift   <= w_aligned;
                        r_len     <= w_eff_len;
                        r_bit_cnt <= w_eff_len - LEN_W'(1);
                        r_rep     <= repeat_cnt;
                    end
                end
                S_SHIFT: begin
                    r_shift <= r_shift << 1;
                    if (!w_last_bit)
                        r_bit_cnt <= r_bit_cnt - LEN_W'(1);
                    else if (r_rep != '0)
                        r_rep <= r_rep - CNT_W'(1);
                end
                S_GAP: begin
                    r_shift   <= r_pat;
                    r_bit_cnt <= r_len - LEN_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        sequence_out = 1'b0;
        bit_valid    = 1'b0;
        frame_start  = 1'b0;
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        if (r_state == S_SHIFT) begin
            sequence_out = r_shift[PAT_W-1];
            bit_valid    = 1'b1;
            frame_start  = (r_bit_cnt == r_len - LEN_W'(1));
        end
    end

endmodule

// File: tb/tb_sequence_generator_fsm.sv
// Bench for sequence_generator_fsm: per-cycle output vectors compared against a frame-level model.
module tb_sequence_generator_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] pat_len = '0;
    logic [3:0] repeat_cnt = '0;
    logic       sequence_out, bit_valid, frame_start, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] exp_q[$];
    logic [4:0] obs;

    localparam logic [4:0] V_IDLE = 5'b00000;
    localparam logic [4:0] V_GAP  = 5'b00010;
    localparam logic [4:0] V_DONE = 5'b00011;

    sequence_generator_fsm #(.PAT_W(8), .LEN_W(4), .CNT_W(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .pattern      (pattern),
        .pat_len      (pat_len),
        .repeat_cnt   (repeat_cnt),
        .sequence_out (sequence_out),
        .bit_valid    (bit_valid),
        .frame_start  (frame_start),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    assign obs = {sequence_out, bit_valid, frame_start, busy, done};

    // Expected output vector {seq, vld, fs, busy, done} for every cycle after the start edge.
    task automatic build_exp(input logic [7:0] pat, input int len, input int rep);
        int l;
        l = (len > 8) ? 8 : len;
        for (int f = 0; f <= rep; f++) begin
            for (int i = l - 1; i >= 0; i--)
                exp_q.push_back({pat[i], 1'b1, (i == l - 1), 1'b1, 1'b0});
            if (f < rep) exp_q.push_back(V_GAP);
        end
        exp_q.push_back(V_DONE);
    endtask

    task automatic launch(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep);
        @(negedge clock);
        pattern    = pat;
        pat_len    = len;
        repeat_cnt = rep;
        start      = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        n_cmp++;
        if (obs !== V_IDLE) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want %b", obs, V_IDLE);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (obs !== V_IDLE) begin
            n_err++;
            $display("FAIL reset_idle: got %b want %b", obs, V_IDLE);
        end
    endtask

    task automatic test_single();
        exp_q.delete();
        build_exp(8'b0000_0101, 3, 0);
        exp_q.push_back(V_IDLE);
        launch(8'b0000_0101, 4'd3, 4'd0);
        foreach (exp_q[k]) begin
            @(negedge clock);
            start = 1'b0;
            n_cmp++;
            if (obs !== exp_q[k]) begin
                n_err++;
                $display("FAIL single cycle %0d: got %b want %b", k + 1, obs, exp_q[k]);
            end
        end
    endtask

    task automatic test_repeat();
        logic [2:0] hist;
        int det, busy_cyc;
        hist = '0; det = 0; busy_cyc = 0;
        exp_q.delete();
        build_exp(8'b0000_1010, 4, 2);
        exp_q.push_back(V_IDLE);
        launch(8'b0000_1010, 4'd4, 4'd2);
        foreach (exp_q[k]) begin
            @(negedge clock);
            start = 1'b0;
            if (busy) busy_cyc++;
            hist = {hist[1:0], sequence_out};
            if (hist == 3'b101) det++;
            n_cmp++;
            if (obs !== exp_q[k]) begin
                n_err++;
                $display("FAIL repeat cycle %0d: got %b want %b", k + 1, obs, exp_q[k]);
            end
        end
        n_cmp++;
        if (busy_cyc !== 15) begin
            n_err++;
            $display("FAIL repeat_busy_len: got %0d want 15", busy_cyc);
        end
        n_cmp++;
        if (det !== 3) begin
            n_err++;
            $display("FAIL repeat_detect_101: got %0d want 3", det);
        end
    endtask

    task automatic test_zero_len();
        launch(8'hFF, 4'd0, 4'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            n_cmp++;
            if (obs !== V_IDLE) begin
                n_err++;
                $display("FAIL zero_len cycle %0d: got %b want %b", k + 1, obs, V_IDLE);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_overlen();
        exp_q.delete();
        build_exp(8'hA5, 15, 0);
        exp_q.push_back(V_IDLE);
        launch(8'hA5, 4'd15, 4'd0);
        foreach (exp_q[k]) begin
            @(negedge clock);
            start = 1'b0;
            n_cmp++;
            if (obs !== exp_q[k]) begin
                n_err++;
                $display("FAIL overlen cycle %0d: got %b want %b", k + 1, obs, exp_q[k]);
            end
        end
    endtask

    task automatic test_ignore_busy();
        exp_q.delete();
        build_exp(8'h6B, 7, 1);
        exp_q.push_back(V_IDLE);
        launch(8'h6B, 4'd7, 4'd1);
        foreach (exp_q[k]) begin
            @(negedge clock);
            n_cmp++;
            if (obs !== exp_q[k]) begin
                n_err++;
                $display("FAIL ignore_busy cycle %0d: got %b want %b", k + 1, obs, exp_q[k]);
            end
            if (k < exp_q.size() - 2) begin
                start      = 1'b1;
                pattern    = 8'($urandom);
                pat_len    = 4'($urandom_range(1, 15));
                repeat_cnt = 4'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_async_reset();
        exp_q.delete();
        build_exp(8'b0000_1010, 4, 2);
        launch(8'b0000_1010, 4'd4, 4'd2);
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            start = 1'b0;
            n_cmp++;
            if (obs !== exp_q[k]) begin
                n_err++;
                $display("FAIL async_pre cycle %0d: got %b want %b", k + 1, obs, exp_q[k]);
            end
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== V_IDLE) begin
            n_err++;
            $display("FAIL async_reset_immediate: got %b want %b", obs, V_IDLE);
        end
        @(negedge clock);
        n_cmp++;
        if (obs !== V_IDLE) begin
            n_err++;
            $display("FAIL async_reset_held: got %b want %b", obs, V_IDLE);
        end
        #2 reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (obs !== V_IDLE) begin
            n_err++;
            $display("FAIL async_after_release: got %b want %b", obs, V_IDLE);
        end
        exp_q.delete();
        build_exp(8'b0011_0110, 6, 0);
        exp_q.push_back(V_IDLE);
        launch(8'b0011_0110, 4'd6, 4'd0);
        foreach (exp_q[k]) begin
            @(negedge clock);
            start = 1'b0;
            n_cmp++;
            if (obs !== exp_q[k]) begin
                n_err++;
                $display("FAIL async_fresh cycle %0d: got %b want %b", k + 1, obs, exp_q[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat;
        pat = 8'($urandom);
        exp_q.delete();
        for (int r = 0; r < 3; r++) begin
            build_exp(pat, 2, 0);
            exp_q.push_back(V_IDLE);
        end
        exp_q.push_back(V_IDLE);
        launch(pat, 4'd2, 4'd0);
        foreach (exp_q[k]) begin
            @(negedge clock);
            if (k == 10) start = 1'b0;
            n_cmp++;
            if (obs !== exp_q[k]) begin
                n_err++;
                $display("FAIL back_to_back cycle %0d: got %b want %b", k + 1, obs, exp_q[k]);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] pat;
        int len, rep;
        for (int run = 0; run < 20; run++) begin
            pat = 8'($urandom);
            len = $urandom_range(1, 15);
            rep = $urandom_range(0, 3);
            exp_q.delete();
            build_exp(pat, len, rep);
            exp_q.push_back(V_IDLE);
            launch(pat, 4'(len), 4'(rep));
            foreach (exp_q[k]) begin
                @(negedge clock);
                start = 1'b0;
                n_cmp++;
                if (obs !== exp_q[k]) begin
                    n_err++;
                    $display("FAIL random run %0d cycle %0d: got %b want %b (pat %h len %0d rep %0d)",
                             run, k + 1, obs, exp_q[k], pat, len, rep);
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_zero_len();
        test_overlen();
        test_ignore_busy();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
